// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the multicycle core's memory-side bus interface.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } mem_state_t;

    localparam int         MEM_TIMEOUT_DEFAULT = 255;
    localparam logic [1:0] MEM_ALIGN_MASK      = 2'b11;

    // Word accesses only: any set byte-offset bit makes the access illegal.
    function automatic logic is_word_aligned(input logic [1:0] adr_lsb);
        return (adr_lsb & MEM_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state counter for an outstanding bus request; flags the last permitted cycle.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int             W      = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]   TC_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // The FSM leaves REQ on the terminal count, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mem_bus_if.sv
// Converts the datapath's one-access-per-state memory port into a req/ack bus
// with wait states, stalling the controller and flagging aborted accesses.
module mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    output mem_state_t  o_dbg_state
);

    mem_state_t  r_state;
    mem_state_t  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_rdata;

    logic w_any_req;
    logic w_legal;
    logic w_accept;
    logic w_ctr_en;
    logic w_ctr_clr;
    logic w_tc;
    logic w_capture;

    assign w_any_req = MemRead | MemWrite;
    assign w_legal   = (MemRead ^ MemWrite) & is_word_aligned(Adr[1:0]);

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_ctr_clr),
        .i_en  (w_ctr_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_ctr_en  = 1'b0;
        w_ctr_clr = 1'b0;
        case (r_state)
            IDLE: begin
                w_ctr_clr = 1'b1;
                if (w_legal) begin
                    w_accept = 1'b1;
                    w_next   = REQ;
                end else if (w_any_req) begin
                    w_next = ERROR;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    w_next = bus_err ? ERROR : DONE;
                end else begin
                    w_ctr_en = 1'b1;
                    if (w_tc) begin
                        w_next = ERROR;
                    end
                end
            end
            // The controller still holds its request while it advances out of DONE.
            DONE:    w_next = IDLE;
            ERROR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus-facing address/data come only from these registers, never live inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= Adr;
            r_wdata <= WriteData;
            r_we    <= MemWrite;
        end
    end

    assign w_capture = (r_state == REQ) & bus_ack & ~bus_err & ~r_we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= bus_rdata;
        end
    end

    assign bus_req     = (r_state == REQ);
    assign bus_we      = (r_state == REQ) & r_we;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign ReadData    = r_rdata;
    assign Err         = (r_state == ERROR);
    assign Stall       = ((r_state == IDLE) & w_any_req) | (r_state == REQ);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: a default-timeout instance and a TIMEOUT=4
// instance share stimulus, selected by tb_sel; read data is scoreboarded.
module tb_mem_bus_if;
    import mem_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Adr, WriteData;
    logic [31:0] bus_rdata;
    logic        bus_ack, bus_err;
    logic        tb_sel;

    logic [31:0] a_rdata, b_rdata, a_addr, b_addr, a_wdata, b_wdata;
    logic        a_stall, b_stall, a_err, b_err, a_req, b_req, a_we, b_we;
    mem_state_t  a_state, b_state;

    logic [31:0] m_rdata, m_addr, m_wdata;
    logic        m_stall, m_err, m_req, m_we;
    mem_state_t  m_state;

    logic [31:0] exp_q[$];
    logic [31:0] model_a, model_b;
    int          n_pass = 0;
    int          n_total = 0;

    int          r_stall_n, r_req_n, r_err_n, r_err_at;
    logic [31:0] r_addr_seen, r_wd_seen;
    logic        r_we_seen, r_wd_stable;
    logic [31:0] rnd;

    always #5 clk = ~clk;

    mem_bus_if u_dut_a (
        .clk(clk), .reset(reset),
        .MemRead(MemRead & ~tb_sel), .MemWrite(MemWrite & ~tb_sel),
        .Adr(Adr), .WriteData(WriteData), .ReadData(a_rdata),
        .Stall(a_stall), .Err(a_err), .bus_req(a_req), .bus_we(a_we),
        .bus_addr(a_addr), .bus_wdata(a_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack & ~tb_sel), .bus_err(bus_err), .o_dbg_state(a_state)
    );

    mem_bus_if #(.TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .MemRead(MemRead & tb_sel), .MemWrite(MemWrite & tb_sel),
        .Adr(Adr), .WriteData(WriteData), .ReadData(b_rdata),
        .Stall(b_stall), .Err(b_err), .bus_req(b_req), .bus_we(b_we),
        .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack & tb_sel), .bus_err(bus_err), .o_dbg_state(b_state)
    );

    assign m_rdata = tb_sel ? b_rdata : a_rdata;
    assign m_addr  = tb_sel ? b_addr  : a_addr;
    assign m_wdata = tb_sel ? b_wdata : a_wdata;
    assign m_stall = tb_sel ? b_stall : a_stall;
    assign m_err   = tb_sel ? b_err   : a_err;
    assign m_req   = tb_sel ? b_req   : a_req;
    assign m_we    = tb_sel ? b_we    : a_we;
    assign m_state = tb_sel ? b_state : a_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One controller access. waits < 0 means the slave never acks.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] adr,
                              input logic [31:0] wd, input int waits, input logic serr,
                              input logic [31:0] rdata);
        int          c;
        bit          done;
        int          tmo;
        logic [31:0] exp_rd;
        logic        legal;
        tmo    = tb_sel ? 4 : 255;
        legal  = (adr[1:0] == 2'b00) && (rd != wr);
        exp_rd = tb_sel ? model_b : model_a;
        if (legal && rd && waits >= 0 && waits < tmo && !serr) exp_rd = rdata;
        exp_q.push_back(exp_rd);
        if (tb_sel) model_b = exp_rd; else model_a = exp_rd;
        r_stall_n = 0; r_req_n = 0; r_err_n = 0; r_err_at = -1;
        r_addr_seen = '0; r_wd_seen = '0; r_we_seen = 1'b0; r_wd_stable = 1'b1;
        c = 0; done = 0;
        while (!done && c < 400) begin
            @(negedge clk);
            if (c == 0) begin
                MemRead = rd; MemWrite = wr; Adr = adr; WriteData = wd;
            end else begin
                Adr = 32'hFFFF_FFF0; WriteData = 32'h0;
            end
            bus_ack = 1'b0; bus_err = 1'b0;
            #1;
            if (m_stall) r_stall_n++;
            if (m_err) begin r_err_n++; r_err_at = c; end
            if (m_req) begin
                if (r_req_n == 0) begin
                    r_addr_seen = m_addr; r_we_seen = m_we; r_wd_seen = m_wdata;
                end else if (m_wdata !== r_wd_seen) begin
                    r_wd_stable = 1'b0;
                end
                if (waits >= 0 && r_req_n == waits) begin
                    bus_ack = 1'b1; bus_err = serr; bus_rdata = rdata;
                end
                r_req_n++;
            end
            if (c > 0 && !m_stall) begin
                done = 1;
                chk("readdata_scoreboard", m_rdata, exp_q.pop_front());
            end
            c++;
        end
        chk("access_finished", 32'(done), 32'd1);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
        #1;
        chk("back_to_idle", 32'(m_state), 32'(IDLE));
        chk("idle_no_stall", 32'(m_stall), 32'd0);
    endtask

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Adr = '0; WriteData = '0;
        bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0; tb_sel = 1'b0;
        model_a = '0; model_b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(m_state), 32'(IDLE));
        chk("rst_bus_req", 32'(m_req), 32'd0);
        chk("rst_readdata", m_rdata, 32'h0);
        chk("rst_bus_addr", m_addr, 32'h0);
        chk("rst_stall_err", {30'd0, m_stall, m_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait read
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 1'b0, 32'hE3A0_1005);
        chk("zw_stall_cycles", 32'(r_stall_n), 32'd2);
        chk("zw_req_cycles", 32'(r_req_n), 32'd1);
        chk("zw_bus_addr", r_addr_seen, 32'h100);
        chk("zw_bus_we", 32'(r_we_seen), 32'd0);
        chk("zw_no_err", 32'(r_err_n), 32'd0);

        // Write with 3 wait states, WriteData/Adr change during the wait
        run_access(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 3, 1'b0, 32'h0BAD_F00D);
        chk("wr_stall_cycles", 32'(r_stall_n), 32'd5);
        chk("wr_req_cycles", 32'(r_req_n), 32'd4);
        chk("wr_bus_wdata", r_wd_seen, 32'hDEAD_BEEF);
        chk("wr_wdata_stable", 32'(r_wd_stable), 32'd1);
        chk("wr_bus_we", 32'(r_we_seen), 32'd1);
        chk("wr_bus_addr", r_addr_seen, 32'h200);
        chk("wr_no_err", 32'(r_err_n), 32'd0);

        // Misaligned read
        run_access(1'b1, 1'b0, 32'h102, 32'h0, 0, 1'b0, 32'h1111_1111);
        chk("mis_no_req", 32'(r_req_n), 32'd0);
        chk("mis_err_cycle", 32'(r_err_at), 32'd1);
        chk("mis_err_count", 32'(r_err_n), 32'd1);
        chk("mis_stall_cycles", 32'(r_stall_n), 32'd1);

        // Read and write requested together
        run_access(1'b1, 1'b1, 32'h104, 32'h55, 0, 1'b0, 32'h2222_2222);
        chk("both_no_req", 32'(r_req_n), 32'd0);
        chk("both_err_cycle", 32'(r_err_at), 32'd1);

        // Slave error
        run_access(1'b1, 1'b0, 32'h108, 32'h0, 0, 1'b1, 32'h0000_1234);
        chk("serr_err_cycle", 32'(r_err_at), 32'd2);
        chk("serr_err_count", 32'(r_err_n), 32'd1);
        chk("serr_stall_cycles", 32'(r_stall_n), 32'd2);

        // Read with 2 wait states, random data
        rnd = $urandom;
        run_access(1'b1, 1'b0, 32'h10C, 32'h0, 2, 1'b0, rnd);
        chk("w2_stall_cycles", 32'(r_stall_n), 32'd4);
        chk("w2_bus_addr", r_addr_seen, 32'h10C);

        // TIMEOUT=4 instance: good read, then a read that times out
        @(negedge clk);
        tb_sel = 1'b1;
        run_access(1'b1, 1'b0, 32'h40, 32'h0, $urandom_range(0, 3), 1'b0, 32'h0000_CAFE);
        chk("t4_read_no_err", 32'(r_err_n), 32'd0);
        run_access(1'b1, 1'b0, 32'h44, 32'h0, -1, 1'b0, 32'h0);
        chk("tmo_req_cycles", 32'(r_req_n), 32'd4);
        chk("tmo_err_cycle", 32'(r_err_at), 32'd5);
        chk("tmo_err_count", 32'(r_err_n), 32'd1);
        chk("tmo_stall_cycles", 32'(r_stall_n), 32'd5);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("late_ack_state", 32'(m_state), 32'(IDLE));
        chk("late_ack_readdata", m_rdata, 32'h0000_CAFE);
        chk("late_ack_no_req", 32'(m_req), 32'd0);

        // Reset in the middle of a long wait
        @(negedge clk);
        tb_sel = 1'b0;
        @(negedge clk);
        MemRead = 1'b1; Adr = 32'h300;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            Adr = 32'h0;
        end
        #1;
        chk("rmid_req_before", 32'(m_req), 32'd1);
        @(negedge clk);
        reset = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        model_a = '0; model_b = '0;
        chk("rmid_req", 32'(m_req), 32'd0);
        chk("rmid_readdata", m_rdata, 32'h0);
        chk("rmid_state", 32'(m_state), 32'(IDLE));
        chk("rmid_bus_addr", m_addr, 32'h0);
        chk("rmid_stall_err", {30'd0, m_stall, m_err}, 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("rmid_ack_ignored", 32'(m_state), 32'(IDLE));
        chk("rmid_ack_readdata", m_rdata, 32'h0);
        run_access(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h5A5A_0000);
        chk("post_rst_stall", 32'(r_stall_n), 32'd2);
        chk("post_rst_addr", r_addr_seen, 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Memory-side interface for the multicycle ARM core. It sits directly downstream of the datapath's `Adr`/`WriteData` outputs and upstream of its `ReadData` input. It converts the datapath's one-access-per-state memory model into a req/ack bus with arbitrary wait states. It returns a `Stall` to the controller FSM, which holds its current state while `Stall` is high, and reports misaligned, timed-out and bus-error accesses on `Err`.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in REQ without `bus_ack` before abort; legal range 1..65535.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `MemRead` input 1: controller requests a word read at `Adr`.
- `MemWrite` input 1: controller requests a word write of `WriteData` to `Adr`.
- `Adr` input 32: byte address from the datapath address mux.
- `WriteData` input 32: store data (datapath B register).
- `ReadData` output 32: last completed read word; feeds the IR and data register.
- `Stall` output 1: controller must hold its state and all enables.
- `Err` output 1: one-cycle pulse marking an aborted access.
- `bus_req` output 1: bus request, held until acknowledged.
- `bus_we` output 1: 1 = write.
- `bus_addr` output 32: word-aligned address, stable while `bus_req` is high.
- `bus_wdata` output 32: write data, stable while `bus_req` is high.
- `bus_rdata` input 32: read data, valid in the `bus_ack` cycle.
- `bus_ack` input 1: transfer complete.
- `bus_err` input 1: slave error; qualified by `bus_ack`.

## Operation
- **States:** IDLE, REQ, DONE, ERROR.
- **IDLE**
  - No request (`MemRead` = `MemWrite` = 0): stay in IDLE.
  - Exactly one of `MemRead`/`MemWrite` high and `Adr[1:0]` = 00:
    - latch `Adr`, `WriteData` and direction into internal registers;
    - clear the timeout counter;
    - go to REQ.
  - `Adr[1:0]` ≠ 00, or `MemRead` and `MemWrite` both high: go to ERROR. No bus cycle is issued.
- **REQ**
  - `bus_req` = 1; `bus_addr`, `bus_wdata` and `bus_we` come from the latched registers, never from live inputs.
  - `bus_ack` = 1 with `bus_err` = 0: on a read, capture `bus_rdata` into the read register; go to DONE.
  - `bus_ack` = 1 with `bus_err` = 1: go to ERROR. Read data is discarded.
  - No `bus_ack`: increment the counter. When the counter equals `TIMEOUT`-1 and `bus_ack` is still low, go to ERROR.
- **DONE:** always go to IDLE. `MemRead`/`MemWrite` are ignored here, because the controller still holds the request during the cycle in which it advances.
- **ERROR:** `Err` = 1; always go to IDLE.
- **Outputs**
  - `Stall` = (IDLE and (`MemRead` or `MemWrite`)) or REQ. It is combinational, and low in DONE and ERROR.
  - `ReadData` is the read register. It changes only on a successful read capture; writes and errors leave it unchanged.
- **Counter:** width $clog2(TIMEOUT+1); saturating behaviour is never reached, because the abort happens first.
- **Outside REQ:** `bus_ack` arriving in any state other than REQ is ignored, including a late ack after a timeout or a reset.
- **Reset** (`reset` = 0 at an edge), from any state including mid-REQ:
  - state returns to IDLE;
  - `bus_req` 0, `bus_we` 0;
  - `bus_addr`, `bus_wdata`, `ReadData` and the counter are 0;
  - `Err` and `Stall` are 0 on the following cycle unless a new request is present.

## Timing
- **Zero-wait access:**
  - cycle 0: IDLE with request, `Stall` = 1;
  - cycle 1: REQ, `bus_req` = 1, `bus_ack` = 1;
  - cycle 2: DONE, `Stall` = 0, `ReadData` valid.
- Minimum stall is 2 cycles; each wait state adds one.
- Back-to-back accesses incur one extra IDLE cycle after DONE.
- A misaligned access stalls 1 cycle (cycle 0); `Err` pulses in cycle 1.
- Timeout: `Err` pulses `TIMEOUT`+1 cycles after the REQ entry cycle's predecessor. `bus_req` is low from the ERROR cycle onward.
- `bus_rdata` is sampled only in the cycle where REQ and `bus_ack` are both true.

## Structure
- **Package `mem_bus_pkg`:**
  - state enum `mem_state_t` (IDLE, REQ, DONE, ERROR);
  - `MEM_TIMEOUT_DEFAULT` = 255;
  - `MEM_ALIGN_MASK` = 2'b11.
- **Sub-module `bus_timeout_ctr`:** clear, enable and terminal-count output; parameterised by `TIMEOUT`.
- **Remaining logic:** address/data/read registers and the FSM, in `mem_bus_if`.

## Test plan
- **Zero-wait read:** `Adr`=0x100, `MemRead`=1, slave acks in its first REQ cycle with 0xE3A0_1005 → `Stall` high for 2 cycles, `bus_addr`=0x100, `ReadData`=0xE3A0_1005 in cycle 2, `Err` never high.
- **Write with 3 wait states:** `Adr`=0x200, `WriteData`=0xDEAD_BEEF; change `WriteData` to 0 during the wait → `bus_wdata` stays 0xDEAD_BEEF, `bus_we`=1, `Stall` high for 5 cycles, `ReadData` unchanged.
- **Misaligned read:** `Adr`=0x102 → no `bus_req`, `Err` pulse in cycle 1, `Stall` low from cycle 1.
- **Timeout:** `TIMEOUT`=4, slave never acks → `bus_req` high for exactly 4 cycles, then `Err` pulse. A late ack 2 cycles afterwards is ignored and `ReadData` is unchanged.
- **Slave error:** slave asserts `bus_ack`=1, `bus_err`=1 with `bus_rdata`=0x1234 → `Err` pulse, `ReadData` keeps its previous value.
- **Reset mid-REQ:** `reset`=0 for one edge during a 10-cycle wait → `bus_req`=0, `ReadData`=0, state IDLE next cycle. A subsequent read of 0x0 completes normally.
